// File: rtl/pa_isa_pkg.sv
// ISA constants shared by the decode/issue stage: opcodes, instruction field
// positions, default MUL latency and the issued-operand bundle.
package pa_isa_pkg;

   localparam logic [6:0] OP_ADD = 7'h00;
   localparam logic [6:0] OP_SUB = 7'h01;
   localparam logic [6:0] OP_MUL = 7'h02;
   localparam logic [6:0] OP_NOP = 7'h3F;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 25;
   localparam int DST_HI = 24;
   localparam int DST_LO = 20;
   localparam int RS1_HI = 19;
   localparam int RS1_LO = 15;
   localparam int RS2_HI = 14;
   localparam int RS2_LO = 10;
   localparam int OFF_HI = 9;
   localparam int OFF_LO = 0;

   localparam int MUL_LAT_DEFAULT = 5;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  dst;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [9:0]  offsetlo;
   } issue_t;

   localparam issue_t ISSUE_BUBBLE = '{opcode: OP_NOP, dst: 5'd0, src1: 32'd0,
                                       src2: 32'd0, offsetlo: 10'd0};

   function automatic logic is_known_op(input logic [6:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_NOP);
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero, whole array cleared by synchronous reset.
module regfile_2r1w #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits the instruction, reads/bypasses operands and holds
// MUL on the outputs for MUL_LAT cycles. DECODE_ILLEGAL_TRAP_EN adds the illegal-opcode trap.
module decode_issue
   import pa_isa_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT,
   parameter int NREG    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        wb_en,
   input  logic [4:0]  wb_dst,
   input  logic [31:0] wb_data,
   output logic [6:0]  opcode,
   output logic [4:0]  dstin,
   output logic [31:0] src1,
   output logic [31:0] src2,
   output logic [9:0]  offsetlo
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic        illegal_sticky
`endif
);

   typedef enum logic { ISSUE = 1'b0, HOLD = 1'b1 } state_t;

   state_t      state;
   logic [3:0]  cnt;
   issue_t      iss;
   issue_t      dec;
   logic [4:0]  rs1, rs2;
   logic [31:0] rd1, rd2;
   logic        accept;

   // Handshake: instr is consumed on any rising edge with instr_valid && instr_ready;
   // fetch must keep instr and instr_valid stable while instr_ready is low.
   assign instr_ready = (state == ISSUE);
   assign accept      = instr_valid && instr_ready;

   assign rs1 = instr[RS1_HI:RS1_LO];
   assign rs2 = instr[RS2_HI:RS2_LO];

   regfile_2r1w #(.NREG(NREG)) u_rf (
      .clk    (clk),
      .reset  (reset),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rd1),
      .rdata2 (rd2),
      .we     (wb_en),
      .waddr  (wb_dst),
      .wdata  (wb_data)
   );

   always_comb begin
      dec.opcode   = instr[OPC_HI:OPC_LO];
      dec.dst      = instr[DST_HI:DST_LO];
      dec.offsetlo = instr[OFF_HI:OFF_LO];
      // Same-cycle write-back wins over the not-yet-written register content.
      dec.src1 = (wb_en && (wb_dst != 5'd0) && (wb_dst == rs1)) ? wb_data : rd1;
      dec.src2 = (wb_en && (wb_dst != 5'd0) && (wb_dst == rs2)) ? wb_data : rd2;
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!is_known_op(instr[OPC_HI:OPC_LO])) begin
         dec.opcode = OP_NOP;
         dec.dst    = 5'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ISSUE;
         cnt   <= 4'd0;
         iss   <= ISSUE_BUBBLE;
      end else begin
         case (state)
            ISSUE: begin
               if (accept) begin
                  iss <= dec;
                  if (dec.opcode == OP_MUL) begin
                     state <= HOLD;
                     cnt   <= 4'(MUL_LAT - 1);
                  end
               end else begin
                  iss <= ISSUE_BUBBLE;
               end
            end
            HOLD: begin
               // Outputs stay frozen; the final MUL cycle is spent back in ISSUE.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= ISSUE;
            end
            default: state <= ISSUE;
         endcase
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) illegal_sticky <= 1'b0;
      else if (accept && !is_known_op(instr[OPC_HI:OPC_LO])) illegal_sticky <= 1'b1;
   end
`endif

   assign opcode   = iss.opcode;
   assign dstin    = iss.dst;
   assign src1     = iss.src1;
   assign src2     = iss.src2;
   assign offsetlo = iss.offsetlo;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of issue, bypass and MUL occupancy.
module tb_decode_issue;

   localparam int MUL_LAT = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_dst = '0;
   logic [31:0] wb_data = '0;
   logic [6:0]  opcode;
   logic [4:0]  dstin;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [9:0]  offsetlo;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal_sticky;
`endif

   always #5 clk = ~clk;

   decode_issue #(.MUL_LAT(MUL_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .wb_en       (wb_en),
      .wb_dst      (wb_dst),
      .wb_data     (wb_data),
      .opcode      (opcode),
      .dstin       (dstin),
      .src1        (src1),
      .src2        (src2),
      .offsetlo    (offsetlo)
`ifdef DECODE_ILLEGAL_TRAP_EN
      ,
      .illegal_sticky (illegal_sticky)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: architectural registers, remaining cycles the current MUL
   // still occupies the outputs (including the present one), and the last issue.
   logic [31:0] m_regs [32];
   int          m_occ = 0;
   logic        m_sticky = 1'b0;
   int          m_accepts = 0;
   logic [85:0] m_last = '0;
   logic [85:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_dst == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                      input logic [4:0] a, input logic [4:0] b,
                                      input logic [9:0] off);
      return {op, d, a, b, off};
   endfunction

   // Predict the outputs after the coming edge from the inputs now applied,
   // then advance one clock and compare.
   task automatic step();
      logic [85:0] e;
      logic [6:0]  op;
      logic [4:0]  d;
      logic        rdy;
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_occ = 0;
         m_sticky = 1'b0;
         e = {7'h3F, 79'd0};
      end else begin
         rdy = (m_occ <= 1);
         if (instr_valid && rdy) begin
            op = instr[31:25];
            d  = instr[24:20];
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (!(op inside {7'h00, 7'h01, 7'h02, 7'h3F})) begin
               op = 7'h3F;
               d  = 5'd0;
               m_sticky = 1'b1;
            end
`endif
            e = {op, d, m_read(instr[19:15]), m_read(instr[14:10]), instr[9:0]};
            m_occ = (op == 7'h02) ? MUL_LAT : 0;
            m_accepts++;
         end else if (rdy) begin
            e = {7'h3F, 79'd0};
            m_occ = 0;
         end else begin
            e = m_last;
            m_occ--;
         end
         if (wb_en && wb_dst != 5'd0) m_regs[wb_dst] = wb_data;
      end
      m_last = e;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("opcode", 32'(opcode), 32'(e[85:79]));
      check("dstin", 32'(dstin), 32'(e[78:74]));
      check("src1", src1, e[73:42]);
      check("src2", src2, e[41:10]);
      check("offsetlo", 32'(offsetlo), 32'(e[9:0]));
      check("instr_ready", 32'(instr_ready), 32'(m_occ <= 1));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("illegal_sticky", 32'(illegal_sticky), 32'(m_sticky));
`endif
   endtask

   task automatic wb(input logic en, input logic [4:0] d, input logic [31:0] v);
      wb_en = en;
      wb_dst = d;
      wb_data = v;
   endtask

   task automatic issue(input logic v, input logic [31:0] w);
      instr_valid = v;
      instr = w;
   endtask

   initial begin
      int mul_cnt, low_cnt, first, last;
      logic [6:0] seq [12];

      // 1. reset then idle
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      check("t1_idle_opcode", 32'(opcode), 32'h3F);
      check("t1_idle_ready", 32'(instr_ready), 32'd1);

      // 2. write r3/r4 then ADD
      wb(1, 5'd3, 32'h5); step();
      wb(1, 5'd4, 32'h7); step();
      wb(0, 0, 0);
      issue(1, mk(7'h00, 5'd5, 5'd3, 5'd4, 10'd0)); step();
      issue(0, 0);
      check("t2_src1", src1, 32'h5);
      check("t2_src2", src2, 32'h7);
      check("t2_dstin", 32'(dstin), 32'd5);

      // 3. bypass and r0
      wb(1, 5'd3, 32'h12345678);
      issue(1, mk(7'h01, 5'd6, 5'd3, 5'd4, 10'd0)); step();
      check("t3_bypass", src1, 32'h12345678);
      issue(0, 0);
      wb(1, 5'd0, 32'hFFFFFFFF); step();
      wb(0, 0, 0);
      issue(1, mk(7'h00, 5'd7, 5'd0, 5'd3, 10'd0)); step();
      check("t3_r0", src1, 32'h0);
      check("t3_r3_written", src2, 32'h12345678);
      issue(0, 0); step();

      // 4a. MUL followed by queued ADD
      issue(1, mk(7'h02, 5'd8, 5'd3, 5'd4, 10'd1)); step();
      seq[0] = opcode;
      low_cnt = instr_ready ? 0 : 1;
      issue(1, mk(7'h00, 5'd9, 5'd3, 5'd4, 10'd2));
      for (int i = 1; i < 6; i++) begin
         step();
         seq[i] = opcode;
         if (!instr_ready) low_cnt++;
         if (m_accepts >= 6) issue(0, 0);
      end
      issue(0, 0);
      mul_cnt = 0;
      for (int i = 0; i < 5; i++) if (seq[i] == 7'h02) mul_cnt++;
      check("t4_mul_cycles", 32'(mul_cnt), 32'd5);
      check("t4_ready_low", 32'(low_cnt), 32'd4);
      check("t4_add_no_bubble", 32'(seq[5]), 32'h00);
      step();

      // 4b. back-to-back MULs
      begin
         int base;
         base = m_accepts;
         issue(1, mk(7'h02, 5'd10, 5'd3, 5'd4, 10'd0));
         first = -1; last = -1; mul_cnt = 0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (m_accepts - base == 1) issue(1, mk(7'h02, 5'd11, 5'd4, 5'd3, 10'd0));
            if (m_accepts - base >= 2) issue(0, 0);
            if (opcode == 7'h02) begin
               mul_cnt++;
               if (first < 0) first = i;
               last = i;
            end
         end
         check("t4_b2b_count", 32'(mul_cnt), 32'd10);
         check("t4_b2b_contig", 32'(last - first + 1), 32'd10);
      end

      // 1b. reset mid-HOLD
      issue(1, mk(7'h02, 5'd12, 5'd3, 5'd4, 10'd0)); step();
      issue(0, 0);
      step();
      reset = 1'b1; step();
      reset = 1'b0;
      check("t1_rst_hold_opcode", 32'(opcode), 32'h3F);
      check("t1_rst_hold_ready", 32'(instr_ready), 32'd1);
      step();

      // 5. max offset, unknown opcode
      issue(1, mk(7'h00, 5'd1, 5'd0, 5'd0, 10'h3FF)); step();
      check("t5_offsetlo", 32'(offsetlo), 32'h3FF);
      issue(1, mk(7'h10, 5'd2, 5'd0, 5'd0, 10'h0)); step();
      issue(0, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("t5_trap_opcode", 32'(opcode), 32'h3F);
      check("t5_trap_sticky", 32'(illegal_sticky), 32'd1);
`else
      check("t5_passthru_opcode", 32'(opcode), 32'h10);
`endif
      step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (m_occ <= 1) begin
            logic [6:0] op;
            case ($urandom_range(0, 5))
               0: op = 7'h00;
               1: op = 7'h01;
               2: op = 7'h02;
               3: op = 7'h3F;
               default: op = 7'($urandom_range(0, 127));
            endcase
            issue($urandom_range(0, 3) != 0,
                  mk(op, 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     10'($urandom)));
         end
         wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
         step();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that drives the execution stage's operand interface: opcode, dstin, src1, src2 and offsetlo.
- Splits the 32-bit instruction word and reads operands from an internal 32x32 register file.
- Accepts write-back from the result/dstout path.
- Implements the pipeline stall for multi-cycle MUL by holding the MUL issue on its outputs and deasserting instr_ready toward fetch.

Parameters:
- MUL_LAT, 5: number of consecutive cycles MUL is held on the outputs. Legal range is 2..15.
- NREG, 32: register count. Fixed by the 5-bit register fields and not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents an instruction.
- instr  in  32  instruction word. Fields: opcode[31:25], dst[24:20], rs1[19:15], rs2[14:10], offlo[9:0].
- instr_ready  out  1  stage can accept; low while a MUL is being held.
- wb_en  in  1  write-back strobe.
- wb_dst  in  5  write-back register index.
- wb_data  in  32  write-back value.
- opcode  out  7  to execution stage; 7'h3F = NOP/bubble.
- dstin  out  5  destination register index.
- src1  out  32  operand 1.
- src2  out  32  operand 2.
- offsetlo  out  10  immediate low bits.

Behaviour:
- Reset (synchronous, active-high):
  - opcode=7'h3F; dstin, src1, src2, offsetlo = 0.
  - FSM in ISSUE, hold counter = 0, all registers cleared to 0.
  - instr_ready=1 from the first cycle after reset deasserts.
- Reset mid-MUL aborts the hold: next outputs are NOP/zeros in state ISSUE.
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - On wb_en with wb_dst!=0, the write lands at the clock edge.
- Bypass: if wb_en && wb_dst!=0 && wb_dst==rs1 (or rs2) in the cycle an instruction is accepted, the issued src1 (or src2) is wb_data, not the stale register content.
- Accept: handshake completes when instr_valid && instr_ready. Fields and operands are registered to the outputs at that edge (latency 1 cycle).
- Bubble: in ISSUE with instr_valid=0, the next outputs are opcode=7'h3F with all other outputs 0.
- Opcodes:
  - 7'h00 ADD, 7'h01 SUB, 7'h3F NOP: single-cycle issue.
  - 7'h02 MUL: enters HOLD.
  - Any other opcode is issued unchanged, unless the optional feature is enabled.
- FSM states: ISSUE and HOLD.
  - ISSUE: instr_ready=1. Accepting a MUL sets the counter to MUL_LAT-1 and moves to HOLD.
  - HOLD: instr_ready=0. Outputs keep the MUL opcode, dstin, src1, src2 and offsetlo unchanged. The counter decrements each cycle; at 1 the FSM returns to ISSUE. The MUL therefore occupies the outputs for exactly MUL_LAT cycles.
  - HOLD → ISSUE: in that cycle instr_ready is already 1, so a new instruction accepted there issues back-to-back with no bubble. Back-to-back MULs re-enter HOLD.
- Write-back during HOLD: updates the register file normally. Held src1/src2 are not refreshed.
- Fetch rule: instr and instr_valid must stay stable while instr_ready=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes other than 00/01/02/3F are issued as opcode=7'h3F with dstin=0.
  - Adds output illegal_sticky (1 bit, reset 0), set on the accept edge and cleared only by reset.
- Undefined: unknown opcodes pass through unchanged and the port is absent.

Decomposition:
- Package pa_isa_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_MUL, OP_NOP.
  - Field bit-position constants.
  - Default MUL_LAT.
  - Typedef for the decoded issue bundle {opcode, dst, src1, src2, offsetlo}.
- Sub-module regfile_2r1w: 32x32 with two combinational read ports, one synchronous write port, r0 hardwired to zero, and synchronous reset clear.
- Bypass and FSM stay in decode_issue.

Test Plan:
1. Reset, then idle → opcode=7'h3F, src1=src2=0, instr_ready=1. Reset asserted mid-HOLD → NOP next cycle and instr_ready=1.
2. wb r3=0x00000005 and r4=0x00000007, then ADD dst=5 rs1=3 rs2=4 → next cycle opcode=00, dstin=5, src1=5, src2=7.
3. Same-cycle wb r3=0x12345678 together with SUB rs1=3 → src1=0x12345678 (bypass). wb to r0 of 0xFFFFFFFF, then ADD rs1=0 → src1=0.
4. MUL rs1=3 rs2=4, then ADD queued with MUL_LAT=5 → opcode=02 held for 5 cycles, instr_ready low for 4. ADD issues on the 6th cycle with no bubble. Two back-to-back MULs → 10 consecutive cycles of opcode=02.
5. offlo=10'h3FF, ADD → offsetlo=0x3FF. Opcode 7'h10: with DECODE_ILLEGAL_TRAP_EN → opcode=3F, illegal_sticky=1; without it → opcode=10 passed through.
